// File: rtl/mem_dump_serializer.sv
// Walks an inclusive word-address range on memory port B and streams every word to the SPART, MSB first.
// Optional DUMP_HEX_ASCII_EN: each word goes out as upper-case ASCII hex followed by CR LF.
module mem_dump_serializer #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] stop_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_enb,
   output logic [ADDR_W-1:0] mem_addrb,
   input  logic [DATA_W-1:0] mem_doutb,
   output logic [7:0]        tx_data,
   output logic              tx_wr,
   input  logic              tx_rdy
);
   localparam int BYTES = DATA_W / 8;
`ifdef DUMP_HEX_ASCII_EN
   localparam int UNITS = 2 * BYTES + 2;
   localparam int SHIFT = 4;
`else
   localparam int UNITS = BYTES;
   localparam int SHIFT = 8;
`endif
   localparam int CNT_W = $clog2(UNITS + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SEND, S_NEXT, S_DONE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cur_reg, cur_next, last_reg, last_next, addrb_reg, addrb_next;
   logic [DATA_W-1:0] word_reg, word_next, avail_word;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              busy_reg, busy_next, done_reg, done_next;
   logic              enb_reg, enb_next, tx_wr_reg, tx_wr_next, fire;
   logic [7:0]        tx_data_reg, tx_data_next, unit_byte;

   // During WAIT the fresh read data is used directly so the first strobe lands in the first SEND cycle.
   assign avail_word = (state_reg == S_WAIT) ? mem_doutb : word_reg;

`ifdef DUMP_HEX_ASCII_EN
   logic [3:0] nibble;
   always_comb begin
      nibble = avail_word[DATA_W-1 -: 4];
      if (cnt_reg == CNT_W'(UNITS - 2))
         unit_byte = 8'h0D;
      else if (cnt_reg == CNT_W'(UNITS - 1))
         unit_byte = 8'h0A;
      else if (nibble < 4'd10)
         unit_byte = 8'h30 + {4'h0, nibble};
      else
         unit_byte = 8'h37 + {4'h0, nibble};
   end
`else
   assign unit_byte = avail_word[DATA_W-1 -: 8];
`endif

   always_comb begin
      state_next   = state_reg;
      cur_next     = cur_reg;
      last_next    = last_reg;
      word_next    = word_reg;
      cnt_next     = cnt_reg;
      tx_data_next = tx_data_reg;
      tx_wr_next   = 1'b0;
      addrb_next   = addrb_reg;
      fire         = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               cur_next   = start_addr;
               last_next  = stop_addr;
               state_next = (start_addr > stop_addr) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_next   = '0;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            word_next  = mem_doutb;
            fire       = tx_rdy && !tx_wr_reg;
            state_next = S_SEND;
         end
         S_SEND: begin
            // A strobe in the previous cycle masks tx_rdy, since TBR falls one cycle late.
            fire = tx_rdy && !tx_wr_reg && (cnt_reg < CNT_W'(UNITS));
            if (cnt_reg == CNT_W'(UNITS))
               state_next = S_NEXT;
         end
         S_NEXT: begin
            if (cur_reg == last_reg) begin
               state_next = S_DONE;
            end else begin
               cur_next   = cur_reg + ADDR_W'(1);
               state_next = S_LOAD;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      if (fire) begin
         tx_wr_next   = 1'b1;
         tx_data_next = unit_byte;
         word_next    = avail_word << SHIFT;
         cnt_next     = cnt_reg + CNT_W'(1);
      end

      enb_next = (state_next == S_LOAD);
      if (enb_next)
         addrb_next = cur_next;
      done_next = (state_reg == S_DONE);
      busy_next = (state_next != S_IDLE) || (state_reg == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         cur_reg     <= '0;
         last_reg    <= '0;
         word_reg    <= '0;
         cnt_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         enb_reg     <= 1'b0;
         addrb_reg   <= '0;
         tx_data_reg <= '0;
         tx_wr_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cur_reg     <= cur_next;
         last_reg    <= last_next;
         word_reg    <= word_next;
         cnt_reg     <= cnt_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         enb_reg     <= enb_next;
         addrb_reg   <= addrb_next;
         tx_data_reg <= tx_data_next;
         tx_wr_reg   <= tx_wr_next;
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign mem_enb   = enb_reg;
   assign mem_addrb = addrb_reg;
   assign tx_data   = tx_data_reg;
   assign tx_wr     = tx_wr_reg;
endmodule
